// File: rtl/vote_result_scanner.sv
// Snapshots all candidate tallies on start and scans them one per clock.
// Reports the winner, the tie and no-votes flags, and the total; holds them until the next start.
module vote_result_scanner #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8,
  parameter int IDX_W    = 2,
  parameter int TOT_W    = 10
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_CAND*CNT_W-1:0] cand_votes,
  output logic                      busy,
  output logic                      result_valid,
  output logic [IDX_W-1:0]          winner,
  output logic                      tie,
  output logic                      no_votes,
  output logic [TOT_W-1:0]          total
);

  // state | meaning
  // IDLE  | no result yet, waiting for start
  // SCAN  | processing candidate idx, one per clock
  // DONE  | result registered and held, start re-snapshots
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] snap [NUM_CAND];
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] max_r;
  logic [IDX_W-1:0] win_r;
  logic             tie_r;
  logic [TOT_W-1:0] acc;

  logic [CNT_W-1:0] cur;
  logic [CNT_W-1:0] max_nxt;
  logic [IDX_W-1:0] win_nxt;
  logic             tie_nxt;
  logic [TOT_W-1:0] acc_nxt;
  logic             last;

  assign busy         = (state == SCAN);
  assign result_valid = (state == DONE);
  assign last         = (idx == IDX_W'(NUM_CAND - 1));

  // Strictly-greater compare keeps the lowest index on a tie.
  always_comb begin
    cur     = snap[idx];
    acc_nxt = acc + {{(TOT_W-CNT_W){1'b0}}, cur};
    max_nxt = max_r;
    win_nxt = win_r;
    tie_nxt = tie_r;
    if (cur > max_r) begin
      max_nxt = cur;
      win_nxt = idx;
      tie_nxt = 1'b0;
    end else if ((cur == max_r) && (max_r != '0)) begin
      tie_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      for (int i = 0; i < NUM_CAND; i++) snap[i] <= '0;
      idx      <= '0;
      max_r    <= '0;
      win_r    <= '0;
      tie_r    <= 1'b0;
      acc      <= '0;
      winner   <= '0;
      tie      <= 1'b0;
      no_votes <= 1'b0;
      total    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            for (int i = 0; i < NUM_CAND; i++) snap[i] <= cand_votes[i*CNT_W +: CNT_W];
            idx   <= '0;
            max_r <= '0;
            win_r <= '0;
            tie_r <= 1'b0;
            acc   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          acc   <= acc_nxt;
          max_r <= max_nxt;
          win_r <= win_nxt;
          tie_r <= tie_nxt;
          idx   <= idx + IDX_W'(1);
          if (last) begin
            state    <= DONE;
            total    <= acc_nxt;
            no_votes <= (max_nxt == '0);
            winner   <= (max_nxt == '0) ? '0 : win_nxt;
            tie      <= (max_nxt == '0) ? 1'b0 : tie_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_result_scanner.sv
// Directed bench for vote_result_scanner: an abstract result model checked every cycle,
// plus literal expectations for each scenario.
module tb_vote_result_scanner;
  localparam int NC = 4;
  localparam int CW = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [NC*CW-1:0]  cand_votes = '0;
  logic              busy, result_valid, tie, no_votes;
  logic [1:0]        winner;
  logic [9:0]        total;

  int n_checks = 0;
  int n_fail   = 0;

  vote_result_scanner dut (
    .clock(clock), .reset(reset), .start(start), .cand_votes(cand_votes),
    .busy(busy), .result_valid(result_valid), .winner(winner), .tie(tie),
    .no_votes(no_votes), .total(total)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NC*CW-1:0] pack(input int a, input int b, input int c, input int d);
    logic [CW-1:0] x0, x1, x2, x3;
    x0 = CW'(a); x1 = CW'(b); x2 = CW'(c); x3 = CW'(d);
    return {x3, x2, x1, x0};
  endfunction

  // Result straight from the rules: sum, maximum, first index holding it, more than one holder.
  function automatic void evaluate(input logic [NC*CW-1:0] v, output int w, output int t,
                                   output int nv, output int tot);
    int m, holders;
    m = 0; w = 0; tot = 0; holders = 0;
    for (int i = 0; i < NC; i++) begin
      tot += int'(v[i*CW +: CW]);
      if (int'(v[i*CW +: CW]) > m) begin m = int'(v[i*CW +: CW]); w = i; end
    end
    for (int i = 0; i < NC; i++) if (int'(v[i*CW +: CW]) == m) holders++;
    nv = (m == 0) ? 1 : 0;
    t  = (m != 0 && holders > 1) ? 1 : 0;
    if (nv == 1) w = 0;
  endfunction

  int scan_left = 0;
  int exp_valid = 0, exp_w = 0, exp_t = 0, exp_nv = 0, exp_tot = 0;
  int pend_w = 0, pend_t = 0, pend_nv = 0, pend_tot = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_left <= 0; exp_valid <= 0;
      exp_w <= 0; exp_t <= 0; exp_nv <= 0; exp_tot <= 0;
    end else if (scan_left > 0) begin
      scan_left <= scan_left - 1;
      if (scan_left == 1) begin
        exp_valid <= 1;
        exp_w <= pend_w; exp_t <= pend_t; exp_nv <= pend_nv; exp_tot <= pend_tot;
      end
    end else if (start) begin
      int w, t, nv, tot;
      evaluate(cand_votes, w, t, nv, tot);
      pend_w <= w; pend_t <= t; pend_nv <= nv; pend_tot <= tot;
      scan_left <= NC;
      exp_valid <= 0;
    end
  end

  always @(negedge clock) begin
    chk("busy", int'(busy), (scan_left > 0) ? 1 : 0);
    chk("result_valid", int'(result_valid), exp_valid);
    chk("winner", int'(winner), exp_w);
    chk("tie", int'(tie), exp_t);
    chk("no_votes", int'(no_votes), exp_nv);
    chk("total", int'(total), exp_tot);
  end

  task automatic wait_done(output int cyc, output int bcnt);
    cyc = 0; bcnt = 0;
    while (!result_valid && cyc < 20) begin
      if (busy) bcnt++;
      @(negedge clock);
      cyc++;
    end
    if (!result_valid) chk("done_timeout", 0, 1);
  endtask

  task automatic check_result(input string tag, input int w, input int t, input int nv, input int tot);
    chk({tag, "_winner"}, int'(winner), w);
    chk({tag, "_tie"}, int'(tie), t);
    chk({tag, "_no_votes"}, int'(no_votes), nv);
    chk({tag, "_total"}, int'(total), tot);
  endtask

  task automatic run(input string tag, input logic [NC*CW-1:0] v,
                     input int w, input int t, input int nv, input int tot);
    int cyc, bcnt;
    cand_votes = v;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk({tag, "_rv_drop"}, int'(result_valid), 0);
    wait_done(cyc, bcnt);
    chk({tag, "_busy_cycles"}, bcnt, NC);
    chk({tag, "_latency_edges"}, cyc + 1, NC + 1);
    check_result(tag, w, t, nv, tot);
  endtask

  initial begin
    int cyc, bcnt;
    repeat (2) @(negedge clock);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rv", int'(result_valid), 0);
    check_result("reset", 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clock);

    run("t1", pack(3, 7, 2, 5), 1, 0, 0, 17);
    run("t2_tie", pack(4, 9, 9, 1), 1, 1, 0, 23);
    run("t2_zero", pack(0, 0, 0, 0), 0, 0, 1, 0);
    run("t3_full", pack(255, 255, 255, 255), 0, 1, 0, 1020);

    // Inputs change after the snapshot and start is pulsed while busy.
    cand_votes = pack(6, 2, 6, 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cand_votes = pack(0, 0, 50, 0);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(cyc, bcnt);
    check_result("t4", 0, 1, 0, 15);
    repeat (6) @(negedge clock);
    chk("t4_no_rescan_busy", int'(busy), 0);
    chk("t4_no_rescan_rv", int'(result_valid), 1);

    // Reset in the second scan cycle.
    cand_votes = pack(1, 1, 1, 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("t5_busy", int'(busy), 0);
    chk("t5_rv", int'(result_valid), 0);
    check_result("t5_reset", 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run("t5_fresh", pack(2, 8, 8, 9), 3, 0, 0, 27);

    run("t6_restart", pack(1, 2, 3, 0), 2, 0, 0, 6);
    repeat (3) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
